// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions for the write-back stage, decode stage and register file.
package wb_stage_pkg;

    localparam int         DEFAULT_DATA_W = 32;
    localparam int         DEFAULT_REG_AW = 5;
    localparam logic [4:0] REG_ZERO       = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } wb_state_t;

    // Saturating 4-bit increment used for the MDU wait counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        logic [3:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Write-back bus: MEM-stage inputs, MDU handshake and the register-file write port.
interface wb_if
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_AW = DEFAULT_REG_AW
);
    logic              mem_valid;
    logic              mem_RegWrite;
    logic              mem_MemtoReg;
    logic [REG_AW-1:0] mem_write_reg;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_AW-1:0] mdu_reg;
    logic [DATA_W-1:0] mdu_data;
    logic              RegWrite;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              stall_pipe;
    logic              busy_valid;
    logic [REG_AW-1:0] busy_reg;

    modport master (
        output mem_valid, mem_RegWrite, mem_MemtoReg, mem_write_reg, mem_alu_result,
               mem_read_data, mdu_valid, mdu_reg, mdu_data,
        input  mdu_ready, RegWrite, write_reg, write_data, stall_pipe, busy_valid, busy_reg
    );

    modport slave (
        input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_write_reg, mem_alu_result,
               mem_read_data, mdu_valid, mdu_reg, mdu_data,
        output mdu_ready, RegWrite, write_reg, write_data, stall_pipe, busy_valid, busy_reg
    );
endinterface

// File: rtl/wb_stage_mem_wb_reg.sv
// MEM/WB pipeline register: captures the MEM-stage fields when enabled, holds otherwise.
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              d_valid,
    input  logic              d_RegWrite,
    input  logic              d_MemtoReg,
    input  logic [REG_AW-1:0] d_write_reg,
    input  logic [DATA_W-1:0] d_alu_result,
    input  logic [DATA_W-1:0] d_read_data,
    output logic              q_valid,
    output logic              q_RegWrite,
    output logic              q_MemtoReg,
    output logic [REG_AW-1:0] q_write_reg,
    output logic [DATA_W-1:0] q_alu_result,
    output logic [DATA_W-1:0] q_read_data
);

    // Enable-held pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid      <= 1'b0;
            q_RegWrite   <= 1'b0;
            q_MemtoReg   <= 1'b0;
            q_write_reg  <= '0;
            q_alu_result <= '0;
            q_read_data  <= '0;
        end else if (en) begin
            q_valid      <= d_valid;
            q_RegWrite   <= d_RegWrite;
            q_MemtoReg   <= d_MemtoReg;
            q_write_reg  <= d_write_reg;
            q_alu_result <= d_alu_result;
            q_read_data  <= d_read_data;
        end else begin
            q_valid      <= q_valid;
            q_RegWrite   <= q_RegWrite;
            q_MemtoReg   <= q_MemtoReg;
            q_write_reg  <= q_write_reg;
            q_alu_result <= q_alu_result;
            q_read_data  <= q_read_data;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, MemtoReg mux and arbitration of the single
// register-file write port between pipeline results and a buffered MDU result.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int REG_AW   = DEFAULT_REG_AW,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  bus
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    wb_state_t         state_r;
    logic [3:0]        wait_cnt_r;
    logic [REG_AW-1:0] buf_reg_r;
    logic [DATA_W-1:0] buf_data_r;

    logic              wb_valid_s;
    logic              wb_RegWrite_s;
    logic              wb_MemtoReg_s;
    logic [REG_AW-1:0] wb_write_reg_s;
    logic [DATA_W-1:0] wb_alu_result_s;
    logic [DATA_W-1:0] wb_read_data_s;

    logic              pipe_wr_s;
    logic [DATA_W-1:0] pipe_data_s;
    logic              buf_wins_s;
    logic              stall_s;
    logic              wb_en_s;
    logic              ready_s;
    logic              xfer_s;
    logic              we_s;
    logic [REG_AW-1:0] wr_reg_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              busy_s;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .en           (wb_en_s),
        .d_valid      (bus.mem_valid),
        .d_RegWrite   (bus.mem_RegWrite),
        .d_MemtoReg   (bus.mem_MemtoReg),
        .d_write_reg  (bus.mem_write_reg),
        .d_alu_result (bus.mem_alu_result),
        .d_read_data  (bus.mem_read_data),
        .q_valid      (wb_valid_s),
        .q_RegWrite   (wb_RegWrite_s),
        .q_MemtoReg   (wb_MemtoReg_s),
        .q_write_reg  (wb_write_reg_s),
        .q_alu_result (wb_alu_result_s),
        .q_read_data  (wb_read_data_s)
    );

    // Port arbitration, result mux and handshake decode from the current state.
    always_comb begin
        pipe_wr_s   = wb_valid_s & wb_RegWrite_s & (wb_write_reg_s != REG_AW'(REG_ZERO));
        pipe_data_s = wb_MemtoReg_s ? wb_read_data_s : wb_alu_result_s;
        buf_wins_s  = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                buf_wins_s = 1'b0;
                stall_s    = 1'b0;
            end
            PEND: begin
                buf_wins_s = ~pipe_wr_s;
                stall_s    = 1'b0;
            end
            FORCE: begin
                buf_wins_s = 1'b1;
                stall_s    = 1'b1;
            end
            default: begin
                buf_wins_s = 1'b0;
                stall_s    = 1'b0;
            end
        endcase

        if (buf_wins_s) begin
            we_s      = 1'b1;
            wr_reg_s  = buf_reg_r;
            wr_data_s = buf_data_r;
        end else if (pipe_wr_s) begin
            we_s      = 1'b1;
            wr_reg_s  = wb_write_reg_s;
            wr_data_s = pipe_data_s;
        end else begin
            we_s      = 1'b0;
            wr_reg_s  = '0;
            wr_data_s = '0;
        end

        wb_en_s = ~stall_s;
        busy_s  = (state_r != IDLE);
        ready_s = (state_r == IDLE) & rst;
        xfer_s  = bus.mdu_valid & ready_s;
    end

    // MDU buffer FSM with bounded-wait forcing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
            buf_reg_r  <= '0;
            buf_data_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A transfer to r0 is accepted but nothing is kept.
                    if (xfer_s && (bus.mdu_reg != REG_AW'(REG_ZERO))) begin
                        buf_reg_r  <= bus.mdu_reg;
                        buf_data_r <= bus.mdu_data;
                        wait_cnt_r <= 4'd0;
                        state_r    <= PEND;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                PEND: begin
                    if (!pipe_wr_s) begin
                        wait_cnt_r <= 4'd0;
                        state_r    <= IDLE;
                    end else if (wb_write_reg_s == buf_reg_r) begin
                        // Younger pipeline write to the same register supersedes the buffer.
                        wait_cnt_r <= 4'd0;
                        state_r    <= IDLE;
                    end else begin
                        wait_cnt_r <= sat_inc4(wait_cnt_r, WAIT_LAST);
                        if (wait_cnt_r == WAIT_LAST) begin
                            state_r <= FORCE;
                        end else begin
                            state_r <= PEND;
                        end
                    end
                end
                FORCE: begin
                    wait_cnt_r <= 4'd0;
                    state_r    <= IDLE;
                end
                default: begin
                    wait_cnt_r <= 4'd0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mdu_ready  = ready_s;
    assign bus.RegWrite   = we_s;
    assign bus.write_reg  = wr_reg_s;
    assign bus.write_data = wr_data_s;
    assign bus.stall_pipe = stall_s;
    assign bus.busy_valid = busy_s;
    assign bus.busy_reg   = busy_s ? buf_reg_r : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_wb_stage;

    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    wb_if #(.DATA_W(32), .REG_AW(5)) bus_i ();

    wb_stage #(.DATA_W(32), .REG_AW(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: instruction sitting in write-back, plus an optional pending MDU result.
    logic        m_v, m_rw, m_m2r;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata;
    logic        m_has_buf, m_force;
    logic [4:0]  m_buf_rd;
    logic [31:0] m_buf_data;
    int          m_blocked;
    logic        hold_mem;
    int          stall_seen;
    logic [36:0] log_q[$];
    logic [36:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_v = 1'b0; m_rw = 1'b0; m_m2r = 1'b0; m_rd = 5'd0; m_alu = 32'd0; m_rdata = 32'd0;
        m_has_buf = 1'b0; m_force = 1'b0; m_buf_rd = 5'd0; m_buf_data = 32'd0; m_blocked = 0;
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] rdata);
        bus_i.mem_valid = v; bus_i.mem_RegWrite = rw; bus_i.mem_MemtoReg = m2r;
        bus_i.mem_write_reg = rd; bus_i.mem_alu_result = alu; bus_i.mem_read_data = rdata;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] d);
        bus_i.mdu_valid = 1'b1; bus_i.mdu_reg = rd; bus_i.mdu_data = d;
    endtask

    // One clock cycle: check outputs against the model, then advance the model at the edge.
    task automatic tick();
        logic        pw, e_we, e_ready, acc;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        #1;
        if (!rst) model_clear();
        pw = m_v && m_rw && (m_rd != 5'd0);
        e_ready = rst && !m_has_buf;
        if (m_has_buf && (m_force || !pw)) begin
            e_we = 1'b1; e_reg = m_buf_rd; e_data = m_buf_data;
        end else if (pw) begin
            e_we = 1'b1; e_reg = m_rd; e_data = m_m2r ? m_rdata : m_alu;
        end else begin
            e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0;
        end
        chk("RegWrite", bus_i.RegWrite, e_we);
        chk("write_reg", bus_i.write_reg, e_reg);
        chk("write_data", bus_i.write_data, e_data);
        chk("stall_pipe", bus_i.stall_pipe, m_force);
        chk("busy_valid", bus_i.busy_valid, m_has_buf);
        chk("busy_reg", bus_i.busy_reg, m_has_buf ? m_buf_rd : 5'd0);
        chk("mdu_ready", bus_i.mdu_ready, e_ready);
        if (bus_i.RegWrite) log_q.push_back({bus_i.write_reg, bus_i.write_data});
        if (bus_i.stall_pipe) stall_seen++;
        @(posedge clk);
        acc = rst && bus_i.mdu_valid && e_ready;
        if (rst) begin
            if (m_force) begin
                m_has_buf = 1'b0; m_force = 1'b0;
            end else begin
                if (m_has_buf) begin
                    if (!pw || m_rd == m_buf_rd) begin
                        m_has_buf = 1'b0;
                    end else begin
                        m_blocked++;
                        if (m_blocked == MAX_WAIT) m_force = 1'b1;
                    end
                end else if (bus_i.mdu_valid && bus_i.mdu_reg != 5'd0) begin
                    m_has_buf = 1'b1; m_buf_rd = bus_i.mdu_reg; m_buf_data = bus_i.mdu_data;
                    m_blocked = 0;
                end
                m_v = bus_i.mem_valid; m_rw = bus_i.mem_RegWrite; m_m2r = bus_i.mem_MemtoReg;
                m_rd = bus_i.mem_write_reg; m_alu = bus_i.mem_alu_result;
                m_rdata = bus_i.mem_read_data;
            end
        end
        hold_mem = rst && m_force;
        @(negedge clk);
        if (acc) bus_i.mdu_valid = 1'b0;
    endtask

    task automatic bubble();
        set_mem(1'b0, 1'b1, 1'b0, 5'd7, 32'hBAD0_0000, 32'hBAD1_0000);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk(tag, log_q[i], exp_q[i]);
    endtask

    initial begin
        logic [4:0] seq_rd[9];
        n_cmp = 0; n_mis = 0; stall_seen = 0; hold_mem = 1'b0;
        model_clear();
        rst = 1'b0;
        bus_i.mdu_valid = 1'b0; bus_i.mdu_reg = 5'd0; bus_i.mdu_data = 32'd0;
        bubble();
        @(negedge clk);

        // 1: reset with random inputs, then a simple ALU write
        for (int i = 0; i < 4; i++) begin
            set_mem(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
            offer(5'($urandom), $urandom);
            tick();
        end
        #1;
        chk("rst_RegWrite", bus_i.RegWrite, 1'b0);
        chk("rst_ready", bus_i.mdu_ready, 1'b0);
        bus_i.mdu_valid = 1'b0;
        rst = 1'b1;
        bubble(); tick();
        set_mem(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0); tick();
        bubble(); #1;
        chk("t1_we", bus_i.RegWrite, 1'b1);
        chk("t1_reg", bus_i.write_reg, 5'd5);
        chk("t1_data", bus_i.write_data, 32'h1234);
        tick();

        // 2: load path, then r0 never written
        set_mem(1'b1, 1'b1, 1'b1, 5'd9, 32'h5555, 32'hDEAD_BEEF); tick();
        bubble(); #1;
        chk("t2_data", bus_i.write_data, 32'hDEAD_BEEF);
        tick();
        set_mem(1'b1, 1'b1, 1'b0, 5'd0, 32'h77, 32'h0); tick();
        bubble(); #1;
        chk("t2_r0", bus_i.RegWrite, 1'b0);
        tick();

        // 3: MDU drains in an idle slot
        log_q.delete();
        offer(5'd3, 32'd7); tick();
        #1;
        chk("t3_busy", bus_i.busy_valid, 1'b1);
        chk("t3_breg", bus_i.busy_reg, 5'd3);
        tick();
        #1;
        chk("t3_ready", bus_i.mdu_ready, 1'b1);
        tick();
        exp_q = '{{5'd3, 32'd7}};
        check_log("t3_log");

        // 4: forced slot after MAX_WAIT blocked cycles
        log_q.delete(); stall_seen = 0;
        seq_rd = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd15, 5'd0, 5'd0};
        offer(5'd3, 32'd33);
        for (int i = 0; i < 9; i++) begin
            if (seq_rd[i] != 5'd0) set_mem(1'b1, 1'b1, 1'b0, seq_rd[i], 32'd100 + 32'(seq_rd[i]), 32'd0);
            else bubble();
            tick();
        end
        chk("t4_stalls", 64'(stall_seen), 64'd1);
        exp_q = '{{5'd10, 32'd110}, {5'd11, 32'd111}, {5'd12, 32'd112}, {5'd13, 32'd113},
                  {5'd3, 32'd33}, {5'd14, 32'd114}, {5'd15, 32'd115}};
        check_log("t4_log");

        // 5: younger pipeline write to the same register drops the buffer
        log_q.delete();
        offer(5'd8, 32'd1);
        set_mem(1'b1, 1'b1, 1'b0, 5'd8, 32'd2, 32'd0); tick();
        bubble(); tick();
        #1;
        chk("t5_busy", bus_i.busy_valid, 1'b0);
        tick();
        exp_q = '{{5'd8, 32'd2}};
        check_log("t5_log");

        // 6: reset while pending discards the buffered r4
        log_q.delete();
        offer(5'd4, 32'd44);
        set_mem(1'b1, 1'b1, 1'b0, 5'd10, 32'd1, 32'd0); tick();
        set_mem(1'b1, 1'b1, 1'b0, 5'd11, 32'd2, 32'd0); tick();
        rst = 1'b0; bubble(); tick();
        rst = 1'b1; tick(); tick();
        #1;
        chk("t6_ready", bus_i.mdu_ready, 1'b1);
        begin
            int n4 = 0;
            foreach (log_q[i]) if (log_q[i][36:32] == 5'd4) n4++;
            chk("t6_r4", 64'(n4), 64'd0);
        end

        // Random traffic, small register range to provoke WAW and forcing
        for (int i = 0; i < 3000; i++) begin
            if (!hold_mem)
                set_mem($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
                        5'($urandom_range(0, 7)), $urandom, $urandom);
            if (!bus_i.mdu_valid && $urandom_range(0, 3) == 0)
                offer(5'($urandom_range(0, 7)), $urandom);
            if (rst && $urandom_range(0, 299) == 0) rst = 1'b0;
            else rst = 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
